// File: rtl/program_loader.sv
// Boot-time loader: receives a framed byte stream, assembles instructions,
// writes them to program memory and releases the CPU once the checksum matches.
module program_loader #(
   parameter int P_SIZE = 6,
   parameter int I_SIZE = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        inData,
   input  logic              inValid,
   output logic              inReady,
   output logic              wrEn,
   output logic [P_SIZE-1:0] wrAddr,
   output logic [I_SIZE-1:0] wrData,
   output logic              cpuHold,
   output logic              done,
   output logic              error
);

   localparam int BPI = I_SIZE / 8;
   localparam int IW  = (BPI > 1) ? $clog2(BPI) : 1;
   localparam int CW  = P_SIZE + 1;
   // Largest legal word count; an 8-bit COUNT can never exceed it beyond P_SIZE=8.
   localparam logic [8:0]    MAX_K    = (P_SIZE >= 8) ? 9'd256 : 9'(2 ** P_SIZE);
   localparam logic [7:0]    SYNC     = 8'hA5;
   localparam logic [IW-1:0] LAST_IDX = IW'(BPI - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      CHECK = 3'd4,
      DONE  = 3'd5,
      ERROR = 3'd6
   } state_t;

   function automatic logic [7:0] csumAdd(input logic [7:0] sum, input logic [7:0] value);
      return sum + value;
   endfunction

   state_t          state_r;
   state_t          nextState_s;
   logic [7:0]      accum_r;
   logic [7:0]      accum_s;
   logic [I_SIZE-1:0] shift_r;
   logic [I_SIZE-1:0] shift_s;
   logic [CW-1:0]   wordCnt_r;
   logic [CW-1:0]   wordCnt_s;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_s;
   logic [IW-1:0]   byteIdx_r;
   logic [IW-1:0]   byteIdx_s;
   logic            accept_s;

   assign inReady  = ~rst & (state_r != WRITE);
   assign accept_s = inValid & inReady;

   assign wrEn    = (state_r == WRITE);
   assign wrAddr  = wordCnt_r[P_SIZE-1:0];
   assign wrData  = shift_r;
   assign cpuHold = (state_r != DONE);
   assign done    = (state_r == DONE);
   assign error   = (state_r == ERROR);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next-state and datapath next values.
   always_comb begin
      nextState_s = state_r;
      accum_s     = accum_r;
      shift_s     = shift_r;
      wordCnt_s   = wordCnt_r;
      count_s     = count_r;
      byteIdx_s   = byteIdx_r;
      case (state_r)
         IDLE: begin
            if (accept_s && (inData == SYNC)) begin
               nextState_s = COUNT;
            end else begin
               nextState_s = IDLE;
            end
         end
         COUNT: begin
            if (accept_s) begin
               accum_s   = inData;
               count_s   = CW'(inData);
               wordCnt_s = {CW{1'b0}};
               byteIdx_s = {IW{1'b0}};
               if ((inData == 8'd0) || ({1'b0, inData} > MAX_K)) begin
                  nextState_s = ERROR;
               end else begin
                  nextState_s = DATA;
               end
            end else begin
               nextState_s = COUNT;
            end
         end
         DATA: begin
            if (accept_s) begin
               // Bytes arrive most-significant first, so shift in from the bottom.
               shift_s = I_SIZE'({shift_r, inData});
               accum_s = csumAdd(accum_r, inData);
               if (byteIdx_r == LAST_IDX) begin
                  byteIdx_s   = {IW{1'b0}};
                  nextState_s = WRITE;
               end else begin
                  byteIdx_s   = byteIdx_r + IW'(1);
                  nextState_s = DATA;
               end
            end else begin
               nextState_s = DATA;
            end
         end
         WRITE: begin
            wordCnt_s = wordCnt_r + CW'(1);
            if (wordCnt_s == count_r) begin
               nextState_s = CHECK;
            end else begin
               nextState_s = DATA;
            end
         end
         CHECK: begin
            if (accept_s) begin
               if (inData == accum_r) begin
                  nextState_s = DONE;
               end else begin
                  nextState_s = ERROR;
               end
            end else begin
               nextState_s = CHECK;
            end
         end
         DONE, ERROR: begin
            if (accept_s && (inData == SYNC)) begin
               nextState_s = COUNT;
            end else begin
               nextState_s = state_r;
            end
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase
   end

   // Datapath registers: checksum, shift register, counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accum_r   <= 8'd0;
         shift_r   <= {I_SIZE{1'b0}};
         wordCnt_r <= {CW{1'b0}};
         count_r   <= {CW{1'b0}};
         byteIdx_r <= {IW{1'b0}};
      end else begin
         accum_r   <= accum_s;
         shift_r   <= shift_s;
         wordCnt_r <= wordCnt_s;
         count_r   <= count_s;
         byteIdx_r <= byteIdx_s;
      end
   end

endmodule
